mix_column_seq: RTL
===================

MIX_COLUMN_SEQ -- requirements
Module: mix_column_seq

Interface
REQ-001 The block SHALL have parameter W, default 4: field element width; legal values 4 (GF(2^4)) and 8 (GF(2^8)).
REQ-002 The block SHALL have parameter POLY, default 4'h3: low W bits of the reduction polynomial (x^4+x+1 for W=4; 8'h1B for x^8+x^4+x^3+x+1 when W=8).
REQ-003 The block SHALL have parameter NC, default 4: columns per state; legal values 1, 2, 4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous abort.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data/in_inv are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-009 The block SHALL have port in_data, input, 4*NC*W bits: state; column c at [c*4W +: 4W], row r of column at [r*W +: W].
REQ-010 The block SHALL have port in_inv, input, 1 bit: 0 = forward MixColumns, 1 = InvMixColumns.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port out_data, output, 4*NC*W bits: result, packed as in_data.

Function
REQ-014 The block SHALL compute forward output row r of each column as the GF(2^W) sum over k of coef[(k-r) mod 4]*s_k, with coef = (2,3,1,1).
REQ-015 The block SHALL use inverse coefficients (E,B,D,9) for both W=4 and W=8.
REQ-016 The GF multiply SHALL be a polynomial product reduced modulo x^W+POLY, exact for all 2^W x 2^W operand pairs.
REQ-017 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 On the edge where in_valid=1 and in_ready=1, the block SHALL register in_data and in_inv, clear the column counter to 0 and go to BUSY.
REQ-020 In BUSY, the block SHALL process exactly one column per cycle, column index = counter, writing the result in place into the state register, then increment the counter.
REQ-021 On the edge that processes column NC-1, the block SHALL go to DONE.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL be held stable until the edge where out_ready=1; the block SHALL then go to IDLE.
REQ-023 Latency: out_valid SHALL rise exactly NC cycles after the accept edge; minimum spacing between accepts SHALL be NC+2 cycles.
REQ-024 The mode latched at accept SHALL govern the whole state; in_inv changes in BUSY SHALL have no effect.
REQ-025 out_data SHALL equal the state register at all times; its value outside DONE is don't-care to consumers.
REQ-026 A 1 on flush SHALL force IDLE and counter 0 at the next edge from any state, taking priority over accept and out_ready; the result SHALL be discarded with no out_valid pulse.
REQ-027 The column counter SHALL be ceil(log2(NC)) bits wide (minimum 1) and SHALL never index beyond NC-1.
REQ-028 For NC=1, BUSY SHALL last exactly one cycle.

Reset
REQ-029 While rst_n=0, the block SHALL be in state IDLE, with counter=0, state register=0 and latched mode=0, immediately and independent of clk.
REQ-030 During reset, outputs SHALL be in_ready=1, out_valid=0 and out_data=0.
REQ-031 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; no out_valid SHALL follow the release of reset.

Verification
REQ-032 W=4, NC=4, fwd; column0=(1,0,0,0), other columns 0 -> out column0=(2,1,1,3), others 0; out_valid 4 cycles after accept.
REQ-033 W=4, inv; column0=(2,1,1,3) -> (1,0,0,0); random state fwd then inv round-trip -> identity, 1000 vectors.
REQ-034 W=8, POLY=8'h1B, fwd; column (db,13,53,45) -> (8e,4d,a1,bc); inv of (8e,4d,a1,bc) -> (db,13,53,45).
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; in_valid=1 during BUSY -> not accepted.
REQ-036 flush on the 2nd BUSY cycle -> IDLE next edge, no out_valid; in_valid and flush both 1 in IDLE -> no accept.
REQ-037 rst_n pulsed low mid-BUSY -> outputs reset asynchronously, no out_valid after release; NC=1 and NC=2 builds pass REQ-032 with latency 1 and 2.

Source files
------------

// File: rtl/mix_column_seq.sv
// Column-serial MixColumns / InvMixColumns over GF(2^W).
// Accepts a state and transforms one column per cycle in place, then holds the result until it is taken.
module mix_column_seq #(
    parameter int unsigned  W    = 4,
    parameter logic [W-1:0] POLY = 4'h3,
    parameter int unsigned  NC   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NC*W-1:0] in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NC*W-1:0] out_data
);

    localparam int unsigned     CW      = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned     CB      = 4 * W;
    localparam logic [CW-1:0]   LastCol = CW'(NC - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NC*W-1:0]   data_q, data_d;
    logic                mode_q, mode_d;
    logic [CB-1:0]       cur_col;
    logic [CB-1:0]       mixed_col;

    // Shift-and-add multiply; reduction folded in at every doubling step.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p;
        logic [W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < int'(W); i++) begin
            if (b[i]) p = p ^ x;
            x = x[W-1] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [CB-1:0] mix_col(input logic [CB-1:0] col, input logic inv);
        logic [W-1:0]  coef [4];
        logic [W-1:0]  acc;
        logic [CB-1:0] res;
        if (inv) begin
            coef[0] = W'(4'hE);
            coef[1] = W'(4'hB);
            coef[2] = W'(4'hD);
            coef[3] = W'(4'h9);
        end else begin
            coef[0] = W'(4'h2);
            coef[1] = W'(4'h3);
            coef[2] = W'(4'h1);
            coef[3] = W'(4'h1);
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                acc = acc ^ gf_mul(coef[(k - r) & 3], col[k*W +: W]);
            end
            res[r*W +: W] = acc;
        end
        return res;
    endfunction

    assign cur_col   = data_q[int'(cnt_q)*CB +: CB];
    assign mixed_col = mix_col(cur_col, mode_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        mode_d  = in_inv;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    data_d[int'(cnt_q)*CB +: CB] = mixed_col;
                    if (cnt_q == LastCol) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = data_q;

endmodule
